// File: rtl/jam_pkg.sv
// rtl/jam_pkg.sv - shared sizes and server state type for the JAM cost-lookup harness
package jam_pkg;
    localparam int N_WORKERS   = 8;
    localparam int COST_W      = 7;
    localparam int MINCOST_W   = 10;
    localparam int COUNT_W     = 4;
    localparam int IDX_W       = 3;
    localparam int TABLE_DEPTH = N_WORKERS * N_WORKERS;
    localparam int ADDR_W      = 2 * IDX_W;

    typedef enum logic [1:0] {LOAD, RELEASE, RUN, DONE} srv_state_t;
endpackage

// File: rtl/jam_cost_ram.sv
// rtl/jam_cost_ram.sv - 64-entry cost table, synchronous write, asynchronous read
module jam_cost_ram
    import jam_pkg::*;
#(
    parameter int DATA_W = 7
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    // No reset: contents are undefined until the table has been loaded.
    logic [DATA_W-1:0] mem [TABLE_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/jam_cost_server.sv
// rtl/jam_cost_server.sv - loads the cost table, holds JAM in reset, answers lookups, checks the result
module jam_cost_server
    import jam_pkg::srv_state_t, jam_pkg::LOAD, jam_pkg::RELEASE, jam_pkg::RUN, jam_pkg::DONE,
           jam_pkg::MINCOST_W, jam_pkg::COUNT_W, jam_pkg::IDX_W, jam_pkg::ADDR_W, jam_pkg::TABLE_DEPTH;
#(
    parameter int COST_W         = 7,
    parameter int TIMEOUT_CYCLES = 10000000,
    parameter int RST_HOLD       = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [COST_W-1:0]    ld_data,
    input  logic [MINCOST_W-1:0] gold_min_cost,
    input  logic [COUNT_W-1:0]   gold_match_count,
    output logic                 jam_rst,
    input  logic [IDX_W-1:0]     W,
    input  logic [IDX_W-1:0]     J,
    output logic [COST_W-1:0]    Cost,
    input  logic                 Valid,
    input  logic [MINCOST_W-1:0] MinCost,
    input  logic [COUNT_W-1:0]   MatchCount,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout
);
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES);
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    srv_state_t           state;
    logic [ADDR_W-1:0]    addr;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [WD_W-1:0]      watchdog;
    logic [MINCOST_W-1:0] gold_min_q;
    logic [COUNT_W-1:0]   gold_cnt_q;
    logic                 wr_en;

    assign wr_en = (state == LOAD) && ld_valid && ld_ready;

    jam_cost_ram #(
        .DATA_W (COST_W)
    ) u_ram (
        .clk     (CLK),
        .wr_en   (wr_en),
        .wr_addr (addr),
        .wr_data (ld_data),
        .rd_addr ({W, J}),
        .rd_data (Cost)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= LOAD;
            ld_ready <= 1'b1;
            jam_rst  <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            addr     <= '0;
            hold_cnt <= '0;
            watchdog <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (wr_en) begin
                        addr <= addr + ADDR_W'(1);
                        // Golden pair travels with the final beat of the table.
                        if (addr == ADDR_W'(TABLE_DEPTH - 1)) begin
                            gold_min_q <= gold_min_cost;
                            gold_cnt_q <= gold_match_count;
                            ld_ready   <= 1'b0;
                            state      <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
                        hold_cnt <= '0;
                        jam_rst  <= 1'b0;
                        state    <= RUN;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                RUN: begin
                    // A result arriving on the expiry cycle still counts as a result.
                    if (Valid) begin
                        pass  <= (MinCost == gold_min_q) && (MatchCount == gold_cnt_q);
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (watchdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        state   <= DONE;
                    end else begin
                        watchdog <= watchdog + WD_W'(1);
                    end
                end
                DONE: begin
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_jam_cost_server.sv
// tb/tb_jam_cost_server.sv - randomized self-checking bench for jam_cost_server
module tb_jam_cost_server;
    localparam int TO   = 100;
    localparam int HOLD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld_valid = 1'b0;
    logic       ld_ready;
    logic [6:0] ld_data = '0;
    logic [9:0] gold_min_cost = '0;
    logic [3:0] gold_match_count = '0;
    logic       jam_rst;
    logic [2:0] W = '0;
    logic [2:0] J = '0;
    logic [6:0] Cost;
    logic       Valid = 1'b0;
    logic [9:0] MinCost = '0;
    logic [3:0] MatchCount = '0;
    logic       done;
    logic       pass;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jam_cost_server #(
        .COST_W         (7),
        .TIMEOUT_CYCLES (TO),
        .RST_HOLD       (HOLD)
    ) dut (
        .CLK              (clk),
        .RST              (rst),
        .ld_valid         (ld_valid),
        .ld_ready         (ld_ready),
        .ld_data          (ld_data),
        .gold_min_cost    (gold_min_cost),
        .gold_match_count (gold_match_count),
        .jam_rst          (jam_rst),
        .W                (W),
        .J                (J),
        .Cost             (Cost),
        .Valid            (Valid),
        .MinCost          (MinCost),
        .MatchCount       (MatchCount),
        .done             (done),
        .pass             (pass),
        .timeout          (timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Behavioural model: phase 0 loading, 1 holding JAM in reset, 2 running, 3 finished.
    int         m_phase = 0;
    int         m_beats = 0;
    int         m_hold  = 0;
    int         m_run   = 0;
    bit         m_done  = 0;
    bit         m_pass  = 0;
    bit         m_to    = 0;
    int         g_min   = 0;
    int         g_cnt   = 0;
    logic [6:0] tbl [64];
    bit         tbl_ok [64];
    bit         started = 0;

    // Compare outputs against the model, then advance the model with this cycle's inputs.
    always @(negedge clk) begin
        if (started) begin
            check("ld_ready", ld_ready, (m_phase == 0));
            check("jam_rst", jam_rst, (m_phase < 2));
            check("done", done, m_done);
            check("timeout", timeout, m_to);
            if (m_done) check("pass", pass, m_pass);
            if (m_phase >= 2 && tbl_ok[int'({W, J})]) check("cost", Cost, tbl[int'({W, J})]);
        end
        if (rst) begin
            m_phase = 0;
            m_beats = 0;
            m_done  = 0;
            m_pass  = 0;
            m_to    = 0;
            started = 1;
        end else if (started) begin
            case (m_phase)
                0: if (ld_valid) begin
                    tbl[m_beats]    = ld_data;
                    tbl_ok[m_beats] = 1;
                    m_beats++;
                    if (m_beats == 64) begin
                        g_min   = gold_min_cost;
                        g_cnt   = gold_match_count;
                        m_beats = 0;
                        m_hold  = 0;
                        m_phase = 1;
                    end
                end
                1: begin
                    m_hold++;
                    if (m_hold == HOLD) begin
                        m_run   = 0;
                        m_phase = 2;
                    end
                end
                2: begin
                    m_run++;
                    if (Valid) begin
                        m_done  = 1;
                        m_pass  = (MinCost == g_min) && (MatchCount == g_cnt);
                        m_phase = 3;
                    end else if (m_run == TO) begin
                        m_to    = 1;
                        m_done  = 1;
                        m_pass  = 0;
                        m_phase = 3;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ld_valid = 1'b0;
        Valid    = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic load(input int n, input bit rnd);
        for (int k = 0; k < n; k++) begin
            while ($urandom_range(0, 3) == 0) begin
                ld_valid = 1'b0;
                ld_data  = 7'($urandom);
                step();
            end
            ld_valid = 1'b1;
            ld_data  = rnd ? 7'($urandom) : 7'(k % 100);
            step();
        end
        ld_valid = 1'b0;
    endtask

    task automatic wait_run();
        int n = 0;
        while (jam_rst === 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("wait_run", jam_rst, 0);
    endtask

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++) begin
            W          = 3'($urandom);
            J          = 3'($urandom);
            MinCost    = 10'($urandom);
            MatchCount = 4'($urandom);
            step();
        end
    endtask

    initial begin
        int cnt;
        int n;
        logic [9:0] gm;
        logic [3:0] gc;

        step();
        step();
        rst = 1'b0;

        // Known table, same-cycle lookups, matching result, DONE holds.
        do_reset();
        gold_min_cost = 10'd300;
        gold_match_count = 4'd2;
        load(64, 0);
        wait_run();
        W = 3'd3; J = 3'd5; #1;
        check("cost_w3_j5", Cost, 29);
        W = 3'd7; J = 3'd7; #1;
        check("cost_w7_j7", Cost, 63);
        rand_run(10);
        Valid = 1'b1; MinCost = 10'd300; MatchCount = 4'd2;
        step();
        Valid = 1'b0;
        check("match_done", done, 1);
        check("match_pass", pass, 1);
        check("match_timeout", timeout, 0);
        for (int i = 0; i < 6; i++) begin
            Valid = 1'b1; MinCost = 10'($urandom); ld_valid = 1'b1; ld_data = 7'($urandom);
            W = 3'($urandom); J = 3'($urandom);
            step();
        end
        Valid = 1'b0; ld_valid = 1'b0;
        check("hold_pass", pass, 1);
        check("hold_jam_rst", jam_rst, 0);

        // Count mismatch.
        do_reset();
        load(64, 1);
        wait_run();
        rand_run(5);
        Valid = 1'b1; MinCost = 10'd300; MatchCount = 4'd3;
        step();
        Valid = 1'b0;
        check("mismatch_done", done, 1);
        check("mismatch_pass", pass, 0);
        check("mismatch_timeout", timeout, 0);

        // Random golden pairs, random match or near-miss.
        for (int t = 0; t < 4; t++) begin
            do_reset();
            gm = 10'($urandom); gc = 4'($urandom);
            gold_min_cost = gm; gold_match_count = gc;
            load(64, 1);
            gold_min_cost = 10'($urandom); gold_match_count = 4'($urandom);
            wait_run();
            rand_run($urandom_range(0, 40));
            Valid = 1'b1;
            MinCost = (t % 2 == 0) ? gm : gm ^ 10'h200;
            MatchCount = gc;
            step();
            Valid = 1'b0;
            check("rand_pass", pass, (t % 2 == 0));
        end

        // Watchdog expiry after exactly TO run cycles.
        do_reset();
        load(64, 1);
        cnt = 0; n = 0;
        while (done !== 1'b1 && n < 300) begin
            if (jam_rst === 1'b0) cnt++;
            W = 3'($urandom); J = 3'($urandom);
            step();
            n++;
        end
        check("to_run_cycles", cnt, TO);
        check("to_timeout", timeout, 1);
        check("to_done", done, 1);
        check("to_pass", pass, 0);

        // Reset mid-load, then a full reload and the reset-hold window.
        do_reset();
        load(30, 1);
        do_reset();
        check("rst_ld_ready", ld_ready, 1);
        check("rst_jam_rst", jam_rst, 1);
        gold_min_cost = 10'd5; gold_match_count = 4'd1;
        load(64, 1);
        cnt = 0; n = 0;
        while (jam_rst === 1'b1 && n < 20) begin
            if (ld_ready === 1'b0) cnt++;
            step();
            n++;
        end
        check("release_cycles", cnt, HOLD);
        rand_run(20);

        // Result on the expiry cycle wins over the watchdog.
        do_reset();
        gm = 10'($urandom); gc = 4'($urandom);
        gold_min_cost = gm; gold_match_count = gc;
        load(64, 1);
        wait_run();
        rand_run(TO - 1);
        Valid = 1'b1; MinCost = gm; MatchCount = gc;
        step();
        Valid = 1'b0;
        check("edge_pass", pass, 1);
        check("edge_timeout", timeout, 0);
        check("edge_done", done, 1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit actual=running required=finished");
        $fatal(1);
    end
endmodule
